// File: rtl/preadd_mac_accumulator_pkg.sv
// Shared widths, types and the round/shift/saturate helper for the
// pre-add MAC frame accumulator.
package preadd_mac_pkg;

    localparam int AW     = 16;
    localparam int BW     = 16;
    localparam int MW     = AW + 1 + BW;
    localparam int MAXLEN = 16;
    localparam int LW     = $clog2(MAXLEN + 1);
    localparam int ACCW   = MW + $clog2(MAXLEN);
    localparam int OW     = 32;
    localparam int SW     = 6;

    typedef logic signed [ACCW-1:0] acc_t;

    typedef struct packed {
        logic                 sat;
        logic signed [OW-1:0] data;
    } res_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_e;

    // Output clip bounds, one bit wider than the accumulator so the rounding add has headroom.
    localparam logic signed [ACCW:0] OMAX = {{(ACCW + 2 - OW){1'b0}}, {(OW - 1){1'b1}}};
    localparam logic signed [ACCW:0] OMIN = ~OMAX;

    function automatic res_t sat_round(input acc_t res, input logic [SW-1:0] sh);
        logic signed [ACCW:0] ext;
        logic signed [ACCW:0] rnd;
        logic signed [ACCW:0] r;
        res_t                 o;
        ext = {res[ACCW-1], res};
        rnd = '0;
        if (sh >= SW'(ACCW)) begin
            r = res[ACCW-1] ? '1 : '0;
        end else begin
            if (sh != '0) begin
                rnd[sh - 1'b1] = 1'b1;
            end
            r = (ext + rnd) >>> sh;
        end
        if (r > OMAX) begin
            o.sat  = 1'b1;
            o.data = OMAX[OW-1:0];
        end else if (r < OMIN) begin
            o.sat  = 1'b1;
            o.data = OMIN[OW-1:0];
        end else begin
            o.sat  = 1'b0;
            o.data = r[OW-1:0];
        end
        return o;
    endfunction

endpackage

// File: rtl/preadd_mac_accumulator_if.sv
// Sample stream in and result stream out of the frame accumulator.
interface preadd_mac_accumulator_if;
    import preadd_mac_pkg::*;

    // Both streams: a transfer happens on a clock edge where valid & ready are both high;
    // the source holds valid and payload until then, and ready never depends on valid.
    logic                 in_valid;
    logic                 in_ready;
    logic signed [MW-1:0] in_data;
    logic                 in_last;
    logic [LW-1:0]        frame_len;
    logic [SW-1:0]        shift;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_data;
    logic                 out_sat;

    modport master (
        output in_valid, in_data, in_last, frame_len, shift, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_last, frame_len, shift, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );

endinterface

// File: rtl/preadd_mac_accumulator_fifo.sv
// Two-entry first-word-fall-through FIFO with occupancy count.
module sync_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   cnt
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    // A push into a full FIFO is accepted only when the same edge pops.
    assign do_pop  = pop && (cnt != 2'd0);
    assign do_push = push && ((cnt != 2'd2) || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/preadd_mac_accumulator.sv
// Frame accumulator behind the pre-add MAC: sums a frame of products, then
// rounds, shifts and saturates the sum into a 2-deep output buffer.
module preadd_mac_accumulator
    import preadd_mac_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    preadd_mac_accumulator_if.slave   bus,
    output logic                      busy,
    output acc_state_e                fsm_state
);

    acc_state_e     state, state_nx;
    acc_t           acc, acc_nx;
    logic [LW-1:0]  count, count_nx;
    logic [LW-1:0]  len_q, len_nx;
    logic [SW-1:0]  shift_q, shift_nx;
    acc_t           res;
    logic           res_v;
    logic [SW-1:0]  res_shift;

    logic           beat;
    logic           load_res;
    logic           is_last;
    acc_t           in_ext;
    acc_t           sum;
    logic [LW-1:0]  eff_len;
    logic [LW-1:0]  cnt_inc;
    logic [LW-1:0]  lim;
    logic [SW-1:0]  cur_shift;
    logic [1:0]     fifo_cnt;
    res_t           fifo_din;
    res_t           fifo_dout;

    assign beat    = bus.in_valid && bus.in_ready;
    assign in_ext  = {{(ACCW - MW){bus.in_data[MW-1]}}, bus.in_data};
    assign eff_len = (bus.frame_len == '0)              ? LW'(1) :
                     (bus.frame_len > LW'(MAXLEN))      ? LW'(MAXLEN) : bus.frame_len;

    // A beat taken in IDLE opens a frame using the live frame_len/shift.
    assign sum       = (state == IDLE) ? in_ext : acc + in_ext;
    assign cnt_inc   = (state == IDLE) ? LW'(1) : count + LW'(1);
    assign lim       = (state == IDLE) ? eff_len : len_q;
    assign cur_shift = (state == IDLE) ? bus.shift : shift_q;
    assign is_last   = bus.in_last || (cnt_inc == lim);

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        count_nx = count;
        len_nx   = len_q;
        shift_nx = shift_q;
        load_res = 1'b0;
        if (beat) begin
            if (state == IDLE) begin
                len_nx   = eff_len;
                shift_nx = bus.shift;
            end
            if (is_last) begin
                state_nx = IDLE;
                acc_nx   = '0;
                count_nx = '0;
                load_res = 1'b1;
            end else begin
                state_nx = ACCUM;
                acc_nx   = sum;
                count_nx = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            count   <= '0;
            len_q   <= '0;
            shift_q <= '0;
        end else begin
            state   <= state_nx;
            acc     <= acc_nx;
            count   <= count_nx;
            len_q   <= len_nx;
            shift_q <= shift_nx;
        end
    end

    // res_v lasts one cycle: the result is rounded and pushed on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res       <= '0;
            res_v     <= 1'b0;
            res_shift <= '0;
        end else if (load_res) begin
            res       <= sum;
            res_v     <= 1'b1;
            res_shift <= cur_shift;
        end else begin
            res_v     <= 1'b0;
        end
    end

    assign fifo_din = sat_round(res, res_shift);

    sync_fifo2 #(
        .W ($bits(res_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (res_v),
        .din   (fifo_din),
        .pop   (bus.out_valid && bus.out_ready),
        .dout  (fifo_dout),
        .cnt   (fifo_cnt)
    );

    // Counting the pending result keeps a slot free for every accepted last beat.
    assign bus.in_ready  = ({1'b0, fifo_cnt} + 3'(res_v)) < 3'd2;
    assign bus.out_valid = (fifo_cnt != 2'd0);
    assign bus.out_data  = fifo_dout.data;
    assign bus.out_sat   = fifo_dout.sat;
    assign busy          = (state == ACCUM);
    assign fsm_state     = state;

endmodule

// File: tb/tb_preadd_mac_accumulator.sv
// Directed and randomized frames against the frame accumulator with an output scoreboard.
module tb_preadd_mac_accumulator;
    import preadd_mac_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy;
    acc_state_e fsm_state;

    always #5 clk = ~clk;

    preadd_mac_accumulator_if bus();

    preadd_mac_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    logic [OW:0] exp_q[$];
    logic [OW:0] mon_exp;
    logic        rdy_rand  = 1'b0;
    logic        rdy_force = 1'b1;
    logic        rdy_bit   = 1'b1;

    assign bus.out_ready = rdy_rand ? rdy_bit : rdy_force;

    always @(posedge clk) begin
        #1;
        rdy_bit = 1'($urandom_range(0, 1));
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: a transfer is decided at the next posedge, inputs are stable at negedge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 64'({bus.out_sat, bus.out_data}), 64'hDEAD);
            end else begin
                mon_exp = exp_q.pop_front();
                check("out_stream", 64'({bus.out_sat, bus.out_data}), 64'(mon_exp));
            end
        end
    end

    function automatic logic [OW:0] model(input longint sum, input int sh);
        longint r;
        if (sh >= ACCW)  r = (sum < 0) ? -1 : 0;
        else if (sh > 0) r = (sum + (longint'(1) <<< (sh - 1))) >>> sh;
        else             r = sum;
        if (r > 64'sd2147483647)  return {1'b1, 32'h7FFFFFFF};
        if (r < -64'sd2147483648) return {1'b1, 32'h80000000};
        return {1'b0, r[31:0]};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called and returns at posedge+1; holds the beat until accepted.
    task automatic send(input longint d, input logic last, input int len, input int sh);
        int n;
        n = 0;
        bus.in_valid  = 1'b1;
        bus.in_data   = d[MW-1:0];
        bus.in_last   = last;
        bus.frame_len = LW'(len);
        bus.shift     = SW'(sh);
        while (!bus.in_ready && n < 200) begin
            idle(1);
            n++;
        end
        if (n >= 200) check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        idle(1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [OW:0] e);
        check({tag, "_early"}, 64'(bus.out_valid), 64'd0);
        idle(1);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_data"}, 64'({bus.out_sat, bus.out_data}), 64'(e));
    endtask

    initial begin
        int n;
        bus.in_valid  = 1'b1;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.frame_len = '0;
        bus.shift     = '0;

        // Reset held with in_valid high
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_data", 64'({bus.out_sat, bus.out_data}), 64'd0);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        idle(1);

        // 4-beat frame, no shift: 3-5+7+10 = 15
        exp_q.push_back({1'b0, 32'd15});
        send(3, 0, 4, 0);
        send(-5, 0, 4, 0);
        send(7, 0, 4, 0);
        check("t2_busy", 64'(busy), 64'd1);
        send(10, 0, 4, 0);
        check("t2_busy_done", 64'(busy), 64'd0);
        expect_out("t2", {1'b0, 32'd15});
        idle(2);

        // Early end via in_last: (7 + 2) >>> 2 = 2
        exp_q.push_back({1'b0, 32'd2});
        send(5, 0, 8, 2);
        send(2, 1, 8, 2);
        expect_out("t3", {1'b0, 32'd2});
        idle(2);

        // 16 x 2^31 = 2^35 clips high; 16 x -2^31 clips low
        exp_q.push_back({1'b1, 32'h7FFFFFFF});
        for (int i = 0; i < 16; i++) send(longint'(1) <<< 31, 0, 16, 0);
        expect_out("t4_pos", {1'b1, 32'h7FFFFFFF});
        idle(2);
        exp_q.push_back({1'b1, 32'h80000000});
        for (int i = 0; i < 16; i++) send(-(longint'(1) <<< 31), 0, 16, 0);
        expect_out("t4_neg", {1'b1, 32'h80000000});
        idle(2);

        // frame_len 0 behaves as 1; frame_len 20 clamps to 16
        exp_q.push_back({1'b0, 32'd9});
        send(9, 0, 0, 0);
        expect_out("len0", {1'b0, 32'd9});
        idle(2);
        exp_q.push_back({1'b0, 32'd16});
        for (int i = 0; i < 16; i++) send(1, 0, 20, 0);
        check("len_clamp_busy", 64'(busy), 64'd0);
        expect_out("len_clamp", {1'b0, 32'd16});
        idle(2);

        // Rounding half toward +inf and oversize shifts, as 1-sample frames
        exp_q.push_back({1'b0, 32'hFFFFFFFF});
        send(-6, 0, 1, 2);
        expect_out("rnd_m6_s2", {1'b0, 32'hFFFFFFFF});
        exp_q.push_back({1'b0, 32'hFFFFFFFE});
        send(-5, 0, 1, 1);
        expect_out("rnd_m5_s1", {1'b0, 32'hFFFFFFFE});
        exp_q.push_back({1'b0, 32'd4});
        send(7, 0, 1, 1);
        expect_out("rnd_7_s1", {1'b0, 32'd4});
        exp_q.push_back({1'b0, 32'd0});
        send(100, 0, 1, 40);
        expect_out("big_shift_pos", {1'b0, 32'd0});
        exp_q.push_back({1'b0, 32'hFFFFFFFF});
        send(-(longint'(1) <<< 32), 0, 1, 63);
        expect_out("big_shift_neg", {1'b0, 32'hFFFFFFFF});
        idle(2);

        // Backpressure: two buffered results stall input, order preserved
        rdy_force = 1'b0;
        exp_q.push_back({1'b0, 32'd1});
        exp_q.push_back({1'b0, 32'd2});
        exp_q.push_back({1'b0, 32'd3});
        send(1, 0, 1, 0);
        send(2, 0, 1, 0);
        check("bp_ready_low", 64'(bus.in_ready), 64'd0);
        idle(1);
        check("bp_ready_full", 64'(bus.in_ready), 64'd0);
        check("bp_head", 64'({bus.out_sat, bus.out_data}), 64'd1);
        idle(1);
        check("bp_head_stable", 64'({bus.out_sat, bus.out_data}), 64'd1);
        rdy_force = 1'b1;
        send(3, 0, 1, 0);
        idle(4);
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // Reset mid-frame with one buffered result
        rdy_force = 1'b0;
        exp_q.push_back({1'b0, 32'd100});
        send(100, 0, 1, 0);
        send(50, 0, 4, 0);
        send(60, 0, 4, 0);
        check("mid_busy", 64'(busy), 64'd1);
        check("mid_buffered", 64'(bus.out_valid), 64'd1);
        rst_n = 1'b0;
        exp_q.delete();
        idle(1);
        check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_ready", 64'(bus.in_ready), 64'd1);
        rst_n = 1'b1;
        rdy_force = 1'b1;
        idle(1);
        exp_q.push_back({1'b0, 32'd15});
        send(7, 0, 2, 0);
        send(8, 0, 2, 0);
        expect_out("post_rst", {1'b0, 32'd15});
        idle(2);

        // Random frames with random output readiness
        rdy_rand = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int     len;
            int     eff;
            int     sh;
            longint sum;
            len = $urandom_range(0, 6);
            eff = (len == 0) ? 1 : len;
            sh  = $urandom_range(0, 4);
            sum = 0;
            for (int i = 0; i < eff; i++) begin
                longint v;
                logic   lst;
                v   = longint'($urandom_range(0, 2000)) - 1000;
                lst = ($urandom_range(0, 4) == 0);
                sum += v;
                if (lst || i == eff - 1) begin
                    exp_q.push_back(model(sum, sh));
                    send(v, lst, (i == 0) ? len : int'($urandom_range(0, 20)), sh);
                    break;
                end
                send(v, lst, (i == 0) ? len : int'($urandom_range(0, 20)), (i == 0) ? sh : int'($urandom_range(0, 63)));
                idle($urandom_range(0, 1));
            end
            idle($urandom_range(0, 2));
        end

        // Drain
        rdy_rand  = 1'b0;
        rdy_force = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            idle(1);
            n++;
        end
        idle(2);
        check("final_pending", 64'(exp_q.size()), 64'd0);
        check("final_out_valid", 64'(bus.out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
